// File: rtl/bcd_timer_pkg.sv
// Shared types and BCD constants for the two-digit BCD down timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit decrementer: subtracts borrow_in, wrapping 0 -> 9 with borrow_out.
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] result,
  output logic       borrow_out
);

  always_comb begin
    result     = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == BCD_ZERO) begin
        result     = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        result = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with load/start/pause control and a tick prescaler.
// Optional build macro BCD_TIMER_AUTO_RELOAD_EN: restart from the reload value instead of stopping at 00.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] preset,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // state  | meaning
  // IDLE   | holding q, accepts load/start
  // RUN    | prescaler counting, q decrements on each tick
  // PAUSED | q and prescaler frozen while pause is high
  // DONE   | reached 00, holds until load or reset

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  state_t     state, state_n;
  logic [7:0] q_n, presc, presc_n, q_dec;
  logic       busy_n, done_n, err_n, load_ok;
  logic       units_borrow, tens_borrow;

  bcd_digit_down u_units (
    .digit      (q[3:0]),
    .borrow_in  (1'b1),
    .result     (q_dec[3:0]),
    .borrow_out (units_borrow)
  );

  bcd_digit_down u_tens (
    .digit      (q[7:4]),
    .borrow_in  (units_borrow),
    .result     (q_dec[7:4]),
    .borrow_out (tens_borrow)
  );

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [7:0] reload;

  always_ff @(posedge clk) begin
    if (rst)          reload <= 8'h00;
    else if (load_ok) reload <= preset;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= 8'h00;
      presc <= 8'h00;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      presc <= presc_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    presc_n = presc;
    done_n  = 1'b0;
    err_n   = 1'b0;
    load_ok = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (load) begin
          if (is_bcd(preset)) begin
            load_ok = 1'b1;
            q_n     = preset;
            state_n = IDLE;
          end else begin
            err_n = 1'b1;
          end
        end else if (start && (state == IDLE)) begin
          if (q != 8'h00) begin
            state_n = RUN;
            presc_n = 8'h00;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN, PAUSED: begin
        // Leaving PAUSED counts in the same edge, so a pause costs exactly its own length.
        if (pause) begin
          state_n = PAUSED;
        end else begin
          state_n = RUN;
          if (presc == TICK_LAST) begin
            presc_n = 8'h00;
            q_n     = tens_borrow ? q : q_dec;
            if (!tens_borrow && (q_dec == 8'h00)) begin
              done_n = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
              q_n = reload;
`else
              state_n = DONE;
`endif
            end
          end else begin
            presc_n = presc + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN) || (state_n == PAUSED);
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, giving clock cycles per count step (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1 bit: request to capture preset.
REQ-005 SHALL have port preset, input, 8 bits: two BCD digits, tens in [7:4], units in [3:0].
REQ-006 SHALL have port start, input, 1 bit: begin countdown.
REQ-007 SHALL have port pause, input, 1 bit: level-sensitive hold while running.
REQ-008 SHALL have port q, output, 8 bits: current count as two BCD digits, registered.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN or PAUSED.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on reaching 00.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on rejected load.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSED and DONE.
REQ-013 Load in IDLE or DONE with both preset nibbles <=9 SHALL make q=preset and the reload register=preset at the next edge; state becomes IDLE.
REQ-014 Load with either nibble >9 SHALL leave q and the reload register unchanged and pulse err for one cycle.
REQ-015 Load in RUN or PAUSED SHALL be ignored (no err).
REQ-016 Load and start high together in IDLE: load SHALL win and start SHALL be ignored.
REQ-017 Start in IDLE with q!=00 SHALL enter RUN at the next edge with the prescaler cleared to 0.
REQ-018 Start in IDLE with q==00 SHALL stay IDLE and pulse done for one cycle.
REQ-019 Start in RUN, PAUSED or DONE SHALL be ignored.
REQ-020 In RUN with pause low, the prescaler SHALL count 0..TICK_DIV-1 and wrap; the tick is the edge at which it equals TICK_DIV-1.
REQ-021 On a tick, q SHALL decrement in BCD: units 0 wraps to 9 with a borrow into tens, otherwise units-1; q never holds a non-BCD value.
REQ-022 Latency: with TICK_DIV=1, the first decrement SHALL occur at the edge after the edge that entered RUN; thereafter one decrement per TICK_DIV cycles.
REQ-023 A tick taking q from 01 to 00 SHALL enter DONE with done=1 in the same cycle q shows 00.
REQ-024 Pause high in RUN SHALL enter PAUSED with q and the prescaler frozen; pause low in PAUSED SHALL return to RUN, resuming the prescaler.
REQ-025 Pause and a tick in the same cycle: pause SHALL win, with no decrement.
REQ-026 In DONE, q SHALL hold 00 and busy SHALL be 0 until a load or reset.
REQ-027 busy SHALL be the registered decode of state (RUN or PAUSED).

Reset
REQ-028 With rst high at an edge: q=8'h00, reload register=8'h00, prescaler=0, state IDLE, busy=0, done=0, err=0.
REQ-029 Reset SHALL take priority over all other inputs, including mid-countdown and mid-pause.

Configuration
REQ-030 Macro BCD_TIMER_AUTO_RELOAD_EN, when defined: on the 01->00 tick, q SHALL load the reload register instead of 00, done SHALL pulse and the state SHALL stay RUN.
REQ-031 Without BCD_TIMER_AUTO_RELOAD_EN, the block SHALL behave per REQ-023/026, with no reload register logic kept.

Structure
REQ-032 Package bcd_timer_pkg SHALL hold the state enum type and the BCD digit constants (BCD_MAX=4'd9).
REQ-033 The block SHALL contain one sub-module, bcd_digit_down: a 4-bit BCD decrement with borrow-in/borrow-out, instantiated once per digit.

Verification
REQ-034 Reset, then load preset=8'h03, start, TICK_DIV=1 -> q is 02, 01, 00 on consecutive edges; done=1 in the 00 cycle only; busy falls with DONE.
REQ-035 Load 8'h10, start -> q goes 10->09 (units wrap 0->9, tens borrow) with no non-BCD value.
REQ-036 Load 8'h1A -> err pulses one cycle and q keeps its prior value; load 8'h99 -> accepted, err=0.
REQ-037 TICK_DIV=4, preset 8'h02, pause held 6 cycles mid-run -> q frozen during pause, done occurs 8+6 cycles after entry to RUN.
REQ-038 rst during RUN at q=8'h05 -> next cycle q=00, IDLE, busy=0; then start with q=00 -> done pulse, state stays IDLE.
REQ-039 With BCD_TIMER_AUTO_RELOAD_EN, preset 8'h02 -> sequence 02, 01, 02 (with done), 01, ...; busy stays 1.
